mrlogic_arbiter: RTL and testbench
==================================

# mrlogic_arbiter

Two-requester arbiter and sequencer for the shared 16-bit logic unit (AND/OR/XOR/NOT plus byte-test ops). It accepts operation requests from two independent clients, grants the unit round-robin, and keeps one 16-bit accumulator per client that feeds the unit's ACC input. It captures the combinational result and returns it through a registered response port, optionally writing it back to the client's accumulator. It sits between the instruction-decode logic of each client and the single logic-unit instance.

## Interface
Parameters:
- none (widths fixed: data 16, opcode 3)

Ports:
- CLK  in  1  clock, all state on rising edge
- RST_N  in  1  synchronous reset, active-low
- A_VALID  in  1  client A request valid
- A_READY  out  1  client A request accepted this cycle
- A_OP  in  3  opcode {O2,O1,O0} for the logic unit
- A_DATA  in  16  operand driven to the unit's D_IN
- A_LOAD  in  1  load A_DATA into ACC_A; no unit operation
- A_WB  in  1  write result back into ACC_A
- B_VALID, B_READY, B_OP, B_DATA, B_LOAD, B_WB  same as above for client B
- RSP_VALID  out  1  response valid
- RSP_READY  in  1  response consumer ready
- RSP_ID  out  1  0 = client A, 1 = client B
- RSP_DATA  out  16  captured result (LOAD: the loaded value)
- LU_D_IN  out  16  to logic unit D_IN
- LU_ACC  out  16  to logic unit ACC
- LU_O2, LU_O1, LU_O0  out  1 each  to logic unit opcode inputs
- LU_OUT  in  16  combinational result from logic unit
- BUSY  out  1  high in any state other than IDLE

## Operation
- Opcode meaning (from the unit): 100 AND, 101 OR, 110 XOR, 111 NOT D_IN; 000 → 0x0001; 001 → 0x0001 iff D_IN[7:0]==0; 010 → 0x0001 iff D_IN[7]==0; 011 → 0x0001 iff D_IN[7]==1; otherwise 0x0000.
- States: IDLE → EXEC → RESP → IDLE.
- IDLE: arbitrate. Only one valid → grant it. Both valid → grant the client not granted last (LAST pointer; reset value LAST=B, so A wins first tie). Grant asserts that client's READY for exactly one cycle and latches OP, DATA, LOAD, WB, ID into request registers. Go to EXEC.
- EXEC: drive LU_D_IN=latched DATA, LU_ACC=ACC[ID], LU_O*=latched OP. Capture RSP_DATA = LOAD ? DATA : LU_OUT. Update ACC[ID] if LOAD, or if WB && OP[2]==1. WB with OP[2]==0 (test ops) is ignored and does not modify ACC. Update LAST=ID. Go to RESP.
- RESP: RSP_VALID=1 and RSP_ID, RSP_DATA held stable until RSP_READY=1. Then go to IDLE.
- The LU_* outputs are driven only in EXEC. Outside EXEC they hold 0, so the unit is idle-quiet.
- READY is never asserted outside IDLE. A client may deassert VALID before it is granted.

## Timing
- Reset (RST_N=0 at a rising edge): state=IDLE, ACC_A=ACC_B=0, LAST=B, RSP_VALID=0, RSP_DATA=0, RSP_ID=0, A_READY=B_READY=0, BUSY=0, LU_* = 0. Reset overrides any state, including mid-EXEC and mid-RESP; the pending response is discarded.
- Grant cycle N (VALID&&READY). EXEC in N+1. RSP_VALID rises at N+2.
- Earliest next grant is the cycle after the RSP handshake. Minimum 3 cycles per operation.
- READY is combinational from VALID and state. It must not depend on RSP_READY.
- An ACC updated in EXEC is visible to that client's next request.
- RSP_READY held high while RSP_VALID rises: response completes in that same cycle (N+2) and IDLE arbitrates at N+3.

## Test plan
- Reset: hold RST_N=0 two cycles → all outputs 0, BUSY=0. Then A_LOAD with A_DATA=0x00FF → RSP_DATA=0x00FF, RSP_ID=0 at grant+2.
- Operation with write-back: ACC_A=0x00FF, A_OP=101 (OR), A_DATA=0x0F00, A_WB=1 → RSP_DATA=0x0FFF. Next A_OP=100 (AND) with A_DATA=0xFFFF → RSP_DATA=0x0FFF. ACC_B remains 0.
- Contention: A and B both valid continuously for 4 requests → grant order A,B,A,B. READY is asserted one-hot and for a single cycle per grant.
- Test ops: B_DATA=0x1200 with B_OP=001 → 0x0001. B_DATA=0x0080 with B_OP=011 → 0x0001, and with B_OP=010 → 0x0000. B_WB=1 leaves ACC_B unchanged.
- Backpressure: RSP_READY=0 for 5 cycles → RSP_VALID and RSP_DATA stable, no READY asserted, BUSY=1. Raising RSP_READY completes the response, and the next grant follows one cycle later.
- Reset mid-operation: drop RST_N during EXEC → the next cycle shows IDLE, RSP_VALID=0, both ACC=0, and no response is issued.

Source files
------------

// File: rtl/mrlogic_arbiter.sv
// Round-robin arbiter/sequencer sharing one 16-bit logic unit between two clients,
// with a per-client accumulator and a registered, backpressured response port.
module mrlogic_arbiter (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        A_VALID,
    output logic        A_READY,
    input  logic [2:0]  A_OP,
    input  logic [15:0] A_DATA,
    input  logic        A_LOAD,
    input  logic        A_WB,
    input  logic        B_VALID,
    output logic        B_READY,
    input  logic [2:0]  B_OP,
    input  logic [15:0] B_DATA,
    input  logic        B_LOAD,
    input  logic        B_WB,
    output logic        RSP_VALID,
    input  logic        RSP_READY,
    output logic        RSP_ID,
    output logic [15:0] RSP_DATA,
    output logic [15:0] LU_D_IN,
    output logic [15:0] LU_ACC,
    output logic        LU_O2,
    output logic        LU_O1,
    output logic        LU_O0,
    input  logic [15:0] LU_OUT,
    output logic        BUSY
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_last;       // 0 = A granted last, 1 = B
    logic [2:0]  r_op;
    logic [15:0] r_data;
    logic        r_load;
    logic        r_wb;
    logic        r_id;
    logic [15:0] r_acc_a;
    logic [15:0] r_acc_b;
    logic [15:0] r_rsp_data;
    logic        r_rsp_id;

    logic        w_grant;
    logic        w_grant_id;
    logic [15:0] w_result;
    logic        w_acc_we;

    always_ff @(posedge CLK) begin
        if (!RST_N) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        A_READY    = 1'b0;
        B_READY    = 1'b0;
        w_grant    = 1'b0;
        w_grant_id = 1'b0;
        LU_D_IN    = 16'h0000;
        LU_ACC     = 16'h0000;
        LU_O2      = 1'b0;
        LU_O1      = 1'b0;
        LU_O0      = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A wins when alone, or on a tie when B was granted last
                if (A_VALID && (!B_VALID || r_last)) begin
                    A_READY = 1'b1;
                    w_grant = 1'b1;
                    w_next  = S_EXEC;
                end else if (B_VALID) begin
                    B_READY    = 1'b1;
                    w_grant    = 1'b1;
                    w_grant_id = 1'b1;
                    w_next     = S_EXEC;
                end
            end
            S_EXEC: begin
                LU_D_IN = r_data;
                LU_ACC  = r_id ? r_acc_b : r_acc_a;
                LU_O2   = r_op[2];
                LU_O1   = r_op[1];
                LU_O0   = r_op[0];
                w_next  = S_RESP;
            end
            S_RESP: begin
                if (RSP_READY) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_result  = r_load ? r_data : LU_OUT;
    // test ops (OP[2]==0) never write back, even with WB set
    assign w_acc_we  = r_load || (r_wb && r_op[2]);
    assign RSP_VALID = (r_state == S_RESP);
    assign RSP_DATA  = r_rsp_data;
    assign RSP_ID    = r_rsp_id;
    assign BUSY      = (r_state != S_IDLE);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_last     <= 1'b1;
            r_op       <= 3'b000;
            r_data     <= 16'h0000;
            r_load     <= 1'b0;
            r_wb       <= 1'b0;
            r_id       <= 1'b0;
            r_acc_a    <= 16'h0000;
            r_acc_b    <= 16'h0000;
            r_rsp_data <= 16'h0000;
            r_rsp_id   <= 1'b0;
        end else begin
            if (w_grant) begin
                r_op   <= w_grant_id ? B_OP   : A_OP;
                r_data <= w_grant_id ? B_DATA : A_DATA;
                r_load <= w_grant_id ? B_LOAD : A_LOAD;
                r_wb   <= w_grant_id ? B_WB   : A_WB;
                r_id   <= w_grant_id;
            end
            if (r_state == S_EXEC) begin
                r_rsp_data <= w_result;
                r_rsp_id   <= r_id;
                r_last     <= r_id;
                if (w_acc_we) begin
                    if (r_id) r_acc_b <= w_result;
                    else      r_acc_a <= w_result;
                end
            end
        end
    end

endmodule

// File: tb/tb_mrlogic_arbiter.sv
// Directed bench for mrlogic_arbiter with a behavioural model of the logic unit.
module tb_mrlogic_arbiter;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        A_VALID, A_READY, A_LOAD, A_WB;
    logic [2:0]  A_OP;
    logic [15:0] A_DATA;
    logic        B_VALID, B_READY, B_LOAD, B_WB;
    logic [2:0]  B_OP;
    logic [15:0] B_DATA;
    logic        RSP_VALID, RSP_READY, RSP_ID;
    logic [15:0] RSP_DATA;
    logic [15:0] LU_D_IN, LU_ACC, LU_OUT;
    logic        LU_O2, LU_O1, LU_O0;
    logic        BUSY;

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    mrlogic_arbiter dut (
        .CLK(CLK), .RST_N(RST_N),
        .A_VALID(A_VALID), .A_READY(A_READY), .A_OP(A_OP), .A_DATA(A_DATA),
        .A_LOAD(A_LOAD), .A_WB(A_WB),
        .B_VALID(B_VALID), .B_READY(B_READY), .B_OP(B_OP), .B_DATA(B_DATA),
        .B_LOAD(B_LOAD), .B_WB(B_WB),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_ID(RSP_ID),
        .RSP_DATA(RSP_DATA),
        .LU_D_IN(LU_D_IN), .LU_ACC(LU_ACC),
        .LU_O2(LU_O2), .LU_O1(LU_O1), .LU_O0(LU_O0),
        .LU_OUT(LU_OUT), .BUSY(BUSY)
    );

    // logic unit model
    always_comb begin
        LU_OUT = 16'h0000;
        case ({LU_O2, LU_O1, LU_O0})
            3'b100: LU_OUT = LU_ACC & LU_D_IN;
            3'b101: LU_OUT = LU_ACC | LU_D_IN;
            3'b110: LU_OUT = LU_ACC ^ LU_D_IN;
            3'b111: LU_OUT = ~LU_D_IN;
            3'b000: LU_OUT = 16'h0001;
            3'b001: LU_OUT = (LU_D_IN[7:0] == 8'h00) ? 16'h0001 : 16'h0000;
            3'b010: LU_OUT = (LU_D_IN[7] == 1'b0)    ? 16'h0001 : 16'h0000;
            3'b011: LU_OUT = (LU_D_IN[7] == 1'b1)    ? 16'h0001 : 16'h0000;
            default: LU_OUT = 16'h0000;
        endcase
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Single uncontended request; entered and left at a negedge with the DUT in IDLE.
    task automatic req(input logic cl, input logic [2:0] op, input logic [15:0] d,
                       input logic ld, input logic wb, input logic [15:0] exp, input string tag);
        if (!cl) begin
            A_VALID = 1'b1; A_OP = op; A_DATA = d; A_LOAD = ld; A_WB = wb;
        end else begin
            B_VALID = 1'b1; B_OP = op; B_DATA = d; B_LOAD = ld; B_WB = wb;
        end
        #1;
        chk({tag, ".a_ready"}, 16'(A_READY), 16'(!cl));
        chk({tag, ".b_ready"}, 16'(B_READY), 16'(cl));
        @(negedge CLK);
        A_VALID = 1'b0; B_VALID = 1'b0;
        chk({tag, ".exec_busy"}, 16'(BUSY), 16'h1);
        chk({tag, ".exec_din"}, LU_D_IN, d);
        chk({tag, ".exec_rspv"}, 16'(RSP_VALID), 16'h0);
        @(negedge CLK);
        chk({tag, ".rsp_valid"}, 16'(RSP_VALID), 16'h1);
        chk({tag, ".rsp_id"}, 16'(RSP_ID), 16'(cl));
        chk({tag, ".rsp_data"}, RSP_DATA, exp);
        @(negedge CLK);
        chk({tag, ".idle_busy"}, 16'(BUSY), 16'h0);
    endtask

    initial begin
        RST_N = 1'b0; RSP_READY = 1'b1;
        A_VALID = 1'b0; A_OP = 3'b000; A_DATA = 16'h0; A_LOAD = 1'b0; A_WB = 1'b0;
        B_VALID = 1'b0; B_OP = 3'b000; B_DATA = 16'h0; B_LOAD = 1'b0; B_WB = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst.rsp_valid", 16'(RSP_VALID), 16'h0);
        chk("rst.rsp_data", RSP_DATA, 16'h0);
        chk("rst.rsp_id", 16'(RSP_ID), 16'h0);
        chk("rst.busy", 16'(BUSY), 16'h0);
        chk("rst.ready", {14'h0, A_READY, B_READY}, 16'h0);
        chk("rst.lu_din", LU_D_IN, 16'h0);
        chk("rst.lu_acc", LU_ACC, 16'h0);
        chk("rst.lu_op", {13'h0, LU_O2, LU_O1, LU_O0}, 16'h0);
        RST_N = 1'b1;
        @(negedge CLK);

        // load, then OR with write-back, then AND without
        req(1'b0, 3'b000, 16'h00FF, 1'b1, 1'b0, 16'h00FF, "a_load");
        req(1'b0, 3'b101, 16'h0F00, 1'b0, 1'b1, 16'h0FFF, "a_or_wb");
        req(1'b0, 3'b100, 16'hFFFF, 1'b0, 1'b0, 16'h0FFF, "a_and");
        req(1'b1, 3'b101, 16'h0000, 1'b0, 1'b0, 16'h0000, "b_acc_zero");

        // contention: last grant was B, so A,B,A,B
        A_VALID = 1'b1; A_OP = 3'b110; A_DATA = 16'h0000; A_LOAD = 1'b0; A_WB = 1'b0;
        B_VALID = 1'b1; B_OP = 3'b000; B_DATA = 16'h0055; B_LOAD = 1'b0; B_WB = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr.a_ready", 16'(A_READY), (i % 2 == 0) ? 16'h1 : 16'h0);
            chk("rr.b_ready", 16'(B_READY), (i % 2 == 1) ? 16'h1 : 16'h0);
            @(negedge CLK);
            chk("rr.exec_ready", {14'h0, A_READY, B_READY}, 16'h0);
            @(negedge CLK);
            chk("rr.rsp_ready", {14'h0, A_READY, B_READY}, 16'h0);
            chk("rr.rsp_id", 16'(RSP_ID), (i % 2 == 1) ? 16'h1 : 16'h0);
            chk("rr.rsp_data", RSP_DATA, (i % 2 == 1) ? 16'h0001 : 16'h0FFF);
            @(negedge CLK);
        end
        A_VALID = 1'b0; B_VALID = 1'b0;

        // byte-test ops; WB on a test op leaves ACC_B alone
        req(1'b1, 3'b001, 16'h1200, 1'b0, 1'b1, 16'h0001, "b_t001");
        req(1'b1, 3'b011, 16'h0080, 1'b0, 1'b1, 16'h0001, "b_t011");
        req(1'b1, 3'b010, 16'h0080, 1'b0, 1'b1, 16'h0000, "b_t010");
        req(1'b1, 3'b101, 16'h0000, 1'b0, 1'b0, 16'h0000, "b_acc_kept");

        // backpressure with B waiting
        RSP_READY = 1'b0;
        A_VALID = 1'b1; A_OP = 3'b110; A_DATA = 16'h00F0; A_LOAD = 1'b0; A_WB = 1'b0;
        B_VALID = 1'b1; B_OP = 3'b000; B_DATA = 16'h0000; B_LOAD = 1'b0; B_WB = 1'b0;
        #1;
        chk("bp.a_grant", {14'h0, A_READY, B_READY}, 16'h2);
        @(negedge CLK);
        A_VALID = 1'b0;
        chk("bp.exec_b_ready", 16'(B_READY), 16'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("bp.rsp_valid", 16'(RSP_VALID), 16'h1);
            chk("bp.rsp_data", RSP_DATA, 16'h0F0F);
            chk("bp.rsp_id", 16'(RSP_ID), 16'h0);
            chk("bp.ready", {14'h0, A_READY, B_READY}, 16'h0);
            chk("bp.busy", 16'(BUSY), 16'h1);
        end
        RSP_READY = 1'b1;
        @(negedge CLK);
        chk("bp.next_grant", {14'h0, A_READY, B_READY}, 16'h1);
        chk("bp.idle", 16'(BUSY), 16'h0);
        @(negedge CLK);
        B_VALID = 1'b0;
        @(negedge CLK);
        chk("bp.b_rsp_id", 16'(RSP_ID), 16'h1);
        chk("bp.b_rsp_data", RSP_DATA, 16'h0001);
        @(negedge CLK);

        // reset during EXEC of a load
        A_VALID = 1'b1; A_OP = 3'b000; A_DATA = 16'h1234; A_LOAD = 1'b1; A_WB = 1'b0;
        @(negedge CLK);
        A_VALID = 1'b0;
        chk("mr.in_exec", 16'(BUSY), 16'h1);
        RST_N = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        chk("mr.busy", 16'(BUSY), 16'h0);
        chk("mr.rsp_valid", 16'(RSP_VALID), 16'h0);
        chk("mr.rsp_data", RSP_DATA, 16'h0);
        chk("mr.lu_din", LU_D_IN, 16'h0);
        @(negedge CLK);
        chk("mr.no_rsp", 16'(RSP_VALID), 16'h0);
        req(1'b0, 3'b101, 16'h0000, 1'b0, 1'b0, 16'h0000, "mr_acc_a");
        req(1'b1, 3'b101, 16'h0000, 1'b0, 1'b0, 16'h0000, "mr_acc_b");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
